// File: rtl/butterfly_in_pkg.sv
// Shared encodings for the butterfly read/write routers: bank selects, radix mode,
// and the layout of the control word that travels alongside a bank read.
package butterfly_in_pkg;

    localparam logic [1:0] SEL_Q0 = 2'd0;
    localparam logic [1:0] SEL_Q1 = 2'd1;
    localparam logic [1:0] SEL_Q2 = 2'd2;
    localparam logic [1:0] SEL_Q3 = 2'd3;

    localparam logic MODE_R2 = 1'b0;
    localparam logic MODE_R4 = 1'b1;

    // Control carried through the read-latency delay line, MSB first.
    typedef struct packed {
        logic       valid;
        logic       mode;
        logic [1:0] sel_0;
        logic [1:0] sel_1;
        logic [1:0] sel_2;
        logic [1:0] sel_3;
    } beat_ctl_t;

    localparam int CTL_WIDTH = $bits(beat_ctl_t);

endpackage

// File: rtl/butterfly_in_delay_line.sv
// Resettable shift register of DEPTH stages; aligns beat control with bank read data.
module delay_line #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // NOTE: every stage is reset (not only the valid bit) so a reset drops in-flight beats cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/butterfly_in.sv
// Read-side crossbar: routes bank data q0..q3 to the two butterflies using selects delayed
// by the bank read latency, flags bank conflicts and marks the last beat of each stage.
module butterfly_in
    import butterfly_in_pkg::*;
#(
    parameter int data_width = 12,
    parameter int RD_LAT     = 1,
    parameter int BEATS      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel_0,
    input  logic                  rd_valid,
    input  logic [1:0]            sel_b_0,
    input  logic [1:0]            sel_b_1,
    input  logic [1:0]            sel_b_2,
    input  logic [1:0]            sel_b_3,
    input  logic [data_width-1:0] q0,
    input  logic [data_width-1:0] q1,
    input  logic [data_width-1:0] q2,
    input  logic [data_width-1:0] q3,
    output logic [data_width-1:0] bf_0_upper,
    output logic [data_width-1:0] bf_0_lower,
    output logic [data_width-1:0] bf_1_upper,
    output logic [data_width-1:0] bf_1_lower,
    output logic                  bf_mode,
    output logic                  out_valid,
    output logic                  conflict,
    output logic                  stage_done
);

    localparam int             CW   = $clog2(BEATS);
    localparam logic [CW-1:0]  LAST = CW'(BEATS - 1);

    beat_ctl_t     ctl_in;
    beat_ctl_t     ctl;
    logic [CW-1:0] count;
    logic          same_bank;

    assign ctl_in = '{valid: rd_valid, mode: sel_0,
                      sel_0: sel_b_0, sel_1: sel_b_1, sel_2: sel_b_2, sel_3: sel_b_3};

    delay_line #(
        .WIDTH (CTL_WIDTH),
        .DEPTH (RD_LAT)
    ) u_ctl_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (ctl_in),
        .dout (ctl)
    );

    function automatic logic [data_width-1:0] route(
        input logic [1:0]            s,
        input logic [data_width-1:0] a,
        input logic [data_width-1:0] b,
        input logic [data_width-1:0] c,
        input logic [data_width-1:0] d
    );
        case (s)
            SEL_Q0:  return a;
            SEL_Q1:  return b;
            SEL_Q2:  return c;
            default: return d;
        endcase
    endfunction

    assign same_bank = (ctl.sel_0 == ctl.sel_1) || (ctl.sel_0 == ctl.sel_2) ||
                       (ctl.sel_0 == ctl.sel_3) || (ctl.sel_1 == ctl.sel_2) ||
                       (ctl.sel_1 == ctl.sel_3) || (ctl.sel_2 == ctl.sel_3);

    // Operands and mode hold across invalid beats; the strobes drop to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            bf_0_upper <= '0;
            bf_0_lower <= '0;
            bf_1_upper <= '0;
            bf_1_lower <= '0;
            bf_mode    <= 1'b0;
            out_valid  <= 1'b0;
            conflict   <= 1'b0;
            stage_done <= 1'b0;
            count      <= '0;
        end else begin
            out_valid  <= ctl.valid;
            conflict   <= ctl.valid && same_bank;
            stage_done <= ctl.valid && (count == LAST);
            if (ctl.valid) begin
                bf_0_upper <= route(ctl.sel_0, q0, q1, q2, q3);
                bf_0_lower <= route(ctl.sel_1, q0, q1, q2, q3);
                bf_1_upper <= route(ctl.sel_2, q0, q1, q2, q3);
                bf_1_lower <= route(ctl.sel_3, q0, q1, q2, q3);
                bf_mode    <= ctl.mode;
                count      <= (count == LAST) ? '0 : count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_butterfly_in.sv
// Bench for butterfly_in: two instances (read latency 1 and 3, 4 beats per stage) share one
// stimulus stream; a bank model returns data after each latency; scoreboards check every cycle.
module tb_butterfly_in;
    import butterfly_in_pkg::*;

    localparam int DW    = 12;
    localparam int BEATS = 4;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct {
        int              issue;
        logic [4*DW-1:0] ops;
        logic            mode;
        logic            conf;
        logic            done;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          rd_valid = 1'b0;
    logic          sel_0 = 1'b0;
    logic [1:0]    sb0 = '0, sb1 = '0, sb2 = '0, sb3 = '0;
    logic [DW-1:0] rd_data [4];

    logic [4*DW-1:0] pipe_a [LAT_A];
    logic [4*DW-1:0] pipe_b [LAT_B];

    // Bank model: data for a read issued this cycle appears LAT cycles later.
    always @(posedge clk) begin
        pipe_a[0] <= {rd_data[0], rd_data[1], rd_data[2], rd_data[3]};
        for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
        pipe_b[0] <= {rd_data[0], rd_data[1], rd_data[2], rd_data[3]};
        for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end

    logic [DW-1:0] oa [4];
    logic [DW-1:0] ob [4];
    logic oa_mode, oa_valid, oa_conf, oa_done;
    logic ob_mode, ob_valid, ob_conf, ob_done;

    butterfly_in #(.data_width(DW), .RD_LAT(LAT_A), .BEATS(BEATS)) dut_a (
        .clk(clk), .rst(rst), .sel_0(sel_0), .rd_valid(rd_valid),
        .sel_b_0(sb0), .sel_b_1(sb1), .sel_b_2(sb2), .sel_b_3(sb3),
        .q0(pipe_a[LAT_A-1][4*DW-1:3*DW]), .q1(pipe_a[LAT_A-1][3*DW-1:2*DW]),
        .q2(pipe_a[LAT_A-1][2*DW-1:DW]),   .q3(pipe_a[LAT_A-1][DW-1:0]),
        .bf_0_upper(oa[0]), .bf_0_lower(oa[1]), .bf_1_upper(oa[2]), .bf_1_lower(oa[3]),
        .bf_mode(oa_mode), .out_valid(oa_valid), .conflict(oa_conf), .stage_done(oa_done)
    );

    butterfly_in #(.data_width(DW), .RD_LAT(LAT_B), .BEATS(BEATS)) dut_b (
        .clk(clk), .rst(rst), .sel_0(sel_0), .rd_valid(rd_valid),
        .sel_b_0(sb0), .sel_b_1(sb1), .sel_b_2(sb2), .sel_b_3(sb3),
        .q0(pipe_b[LAT_B-1][4*DW-1:3*DW]), .q1(pipe_b[LAT_B-1][3*DW-1:2*DW]),
        .q2(pipe_b[LAT_B-1][2*DW-1:DW]),   .q3(pipe_b[LAT_B-1][DW-1:0]),
        .bf_0_upper(ob[0]), .bf_0_lower(ob[1]), .bf_1_upper(ob[2]), .bf_1_lower(ob[3]),
        .bf_mode(ob_mode), .out_valid(ob_valid), .conflict(ob_conf), .stage_done(ob_done)
    );

    exp_t            sb_a[$];
    exp_t            sb_b[$];
    logic [4*DW-1:0] last_ops [2];
    logic            last_mode [2];
    int              cyc = 0;
    int              model_count = 0;
    int              n_tests = 0;
    int              n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int d, input logic ov, input logic mode, input logic conf,
                             input logic done, input logic [4*DW-1:0] ops);
        exp_t  e;
        int    lat;
        int    depth;
        int    due;
        string nm;
        lat   = (d == 0) ? LAT_A : LAT_B;
        nm    = (d == 0) ? "a" : "b";
        depth = (d == 0) ? sb_a.size() : sb_b.size();
        due   = 0;
        if (depth > 0) begin
            e   = (d == 0) ? sb_a[0] : sb_b[0];
            due = (e.issue + lat + 1 == cyc) ? 1 : 0;
        end
        if (ov && depth == 0) begin
            check({nm, ".spurious_valid"}, ov, 1'b0);
        end else if (ov) begin
            if (d == 0) e = sb_a.pop_front();
            else        e = sb_b.pop_front();
            check({nm, ".latency"}, 64'(cyc - e.issue), 64'(lat + 1));
            check({nm, ".ops"}, ops, e.ops);
            check({nm, ".mode"}, mode, e.mode);
            check({nm, ".conflict"}, conf, e.conf);
            check({nm, ".stage_done"}, done, e.done);
            last_ops[d]  = e.ops;
            last_mode[d] = e.mode;
        end else begin
            check({nm, ".out_valid"}, ov, 1'(due));
            check({nm, ".hold_ops"}, ops, last_ops[d]);
            check({nm, ".hold_mode"}, mode, last_mode[d]);
            check({nm, ".idle_conflict"}, conf, 1'b0);
            check({nm, ".idle_stage_done"}, done, 1'b0);
        end
    endtask

    function automatic logic [DW-1:0] pick(input logic [1:0] s, input logic [DW-1:0] d [4]);
        return d[s];
    endfunction

    // One cycle: check both DUTs at the falling edge, then drive the next beat.
    task automatic step(input logic v, input logic m, input logic [1:0] s0, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [1:0] s3,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [DW-1:0] d3, input logic r);
        exp_t       e;
        logic [1:0] s [4];
        logic       c;
        @(negedge clk);
        cyc++;
        check_dut(0, oa_valid, oa_mode, oa_conf, oa_done, {oa[0], oa[1], oa[2], oa[3]});
        check_dut(1, ob_valid, ob_mode, ob_conf, ob_done, {ob[0], ob[1], ob[2], ob[3]});
        rst = r;  rd_valid = v;  sel_0 = m;
        sb0 = s0; sb1 = s1; sb2 = s2; sb3 = s3;
        rd_data[0] = d0; rd_data[1] = d1; rd_data[2] = d2; rd_data[3] = d3;
        if (r) begin
            sb_a.delete();
            sb_b.delete();
            model_count = 0;
            for (int i = 0; i < 2; i++) begin
                last_ops[i]  = '0;
                last_mode[i] = 1'b0;
            end
        end else if (v) begin
            s = '{s0, s1, s2, s3};
            c = 1'b0;
            for (int i = 0; i < 4; i++)
                for (int j = i + 1; j < 4; j++)
                    if (s[i] == s[j]) c = 1'b1;
            e.issue = cyc;
            e.ops   = {pick(s0, rd_data), pick(s1, rd_data), pick(s2, rd_data), pick(s3, rd_data)};
            e.mode  = m;
            e.conf  = c;
            e.done  = (model_count == BEATS - 1);
            model_count = (model_count + 1) % BEATS;
            sb_a.push_back(e);
            sb_b.push_back(e);
        end
    endtask

    task automatic beat(input logic m, input logic [1:0] s0, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [1:0] s3,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        step(1'b1, m, s0, s1, s2, s3, d0, d1, d2, d3, 1'b0);
    endtask

    task automatic rand_beat(input logic v, input logic r);
        step(v, 1'($urandom_range(1)), 2'($urandom_range(3)), 2'($urandom_range(3)),
             2'($urandom_range(3)), 2'($urandom_range(3)), DW'($urandom), DW'($urandom),
             DW'($urandom), DW'($urandom), r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rand_beat(1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            last_ops[i]  = '0;
            last_mode[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) rd_data[i] = '0;
        for (int i = 0; i < 3; i++) rand_beat(1'b0, 1'b1);
        idle(5);

        // Straight routing, then full reversal.
        beat(MODE_R2, SEL_Q0, SEL_Q1, SEL_Q2, SEL_Q3, 12'hA0A, 12'hB0B, 12'hC0C, 12'hD0D);
        idle(5);
        beat(MODE_R2, SEL_Q3, SEL_Q2, SEL_Q1, SEL_Q0, 12'd1, 12'd2, 12'd3, 12'd4);
        idle(5);

        // Mode alternates on back-to-back beats.
        for (int i = 0; i < 6; i++)
            beat(1'(i % 2), 2'(i % 4), 2'((i + 1) % 4), 2'((i + 2) % 4), 2'((i + 3) % 4),
                 DW'(16 * i + 1), DW'(16 * i + 2), DW'(16 * i + 3), DW'(16 * i + 4));
        idle(5);

        // Conflicting beat followed by a clean one.
        beat(MODE_R4, SEL_Q1, SEL_Q1, SEL_Q2, SEL_Q3, 12'h111, 12'h222, 12'h333, 12'h444);
        beat(MODE_R2, SEL_Q2, SEL_Q0, SEL_Q3, SEL_Q1, 12'h555, 12'h666, 12'h777, 12'h888);
        idle(5);

        // Nine beats with two gaps from a fresh count: stage_done on beats 4 and 8.
        rand_beat(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            rand_beat(1'b1, 1'b0);
            if (i == 2 || i == 5) idle(2);
        end
        idle(6);

        // Reset with beats in flight, rd_valid asserted alongside rst.
        for (int i = 0; i < 3; i++) rand_beat(1'b1, 1'b0);
        rand_beat(1'b1, 1'b1);
        idle(6);
        for (int i = 0; i < 4; i++) rand_beat(1'b1, 1'b0);
        idle(6);

        // Long back-to-back random stream.
        for (int i = 0; i < 200; i++) rand_beat(1'b1, 1'b0);
        idle(6);

        check("drain.a", 64'(sb_a.size()), 64'd0);
        check("drain.b", 64'(sb_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
